deser_load_ctrl: RTL and testbench

DESER_LOAD_CTRL -- requirements
Module: deser_load_ctrl

---
 rtl/ann_ctrl_pkg.sv | 21 ++
 rtl/frame_timer.sv | 30 +++
 rtl/deser_load_ctrl.sv | 192 +++++++++++++++++++
 tb/tb_deser_load_ctrl.sv | 233 +++++++++++++++++++++++
 4 files changed

// File: rtl/ann_ctrl_pkg.sv
// Shared command encodings and FSM state type for the deserializer load controller.
// The CHK state exists only when DESER_LOAD_CHECKSUM_EN is defined.
package ann_ctrl_pkg;

    localparam logic [7:0] CMD_LOAD_W = 8'h01;
    localparam logic [7:0] CMD_LOAD_I = 8'h02;
    localparam logic [7:0] CMD_RUN    = 8'h03;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        LEN,
        DATA,
`ifdef DESER_LOAD_CHECKSUM_EN
        CHK,
`endif
        START,
        WAIT_DONE
    } state_t;

endpackage

// File: rtl/frame_timer.sv
// Idle-cycle watchdog: reloads on load, raises timeout on the TIMEOUT_CYC-th
// consecutive enabled cycle without a reload.
module frame_timer #(
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic clk,
    input  logic reset_n,
    input  logic load,
    input  logic enable,
    output logic timeout
);

    localparam int CW = $clog2(TIMEOUT_CYC + 1);
    localparam logic [CW-1:0] LAST = CW'(TIMEOUT_CYC - 1);

    logic [CW-1:0] cnt_q;

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            cnt_q <= '0;
        end else if (load) begin
            cnt_q <= '0;
        end else if (enable && cnt_q != LAST) begin
            cnt_q <= cnt_q + CW'(1);
        end
    end

    assign timeout = enable && !load && (cnt_q == LAST);

endmodule

// File: rtl/deser_load_ctrl.sv
// Frame parser between the byte deserializer and the ANN memories/core.
// Optional trailing XOR checksum byte is enabled with DESER_LOAD_CHECKSUM_EN.
module deser_load_ctrl
    import ann_ctrl_pkg::*;
#(
    parameter int ADDR_W      = 8,
    parameter int TIMEOUT_CYC = 1024
) (
    input  logic              clk,
    input  logic              reset_n,
    input  logic [7:0]        byte_in,
    input  logic              byte_valid,
    output logic              wr_en,
    output logic              wr_sel,
    output logic [ADDR_W-1:0] wr_addr,
    output logic [7:0]        wr_data,
    output logic              nn_start,
    input  logic              nn_done,
    output logic              ctrl_busy,
    output logic              frame_err
);

    state_t            state_q, state_d;
    logic              frame_err_q, frame_err_d;
    logic              wr_sel_q, wr_sel_d;
    logic [ADDR_W-1:0] ptr_q, ptr_d;
    logic [7:0]        left_q, left_d;
    logic              wr_en_q, wr_en_d;
    logic [ADDR_W-1:0] wr_addr_q, wr_addr_d;
    logic [7:0]        wr_data_q, wr_data_d;
`ifdef DESER_LOAD_CHECKSUM_EN
    logic [7:0]        csum_q, csum_d;
`endif

    logic timed;
    logic timeout;

    always_comb begin
        timed = (state_q == ADDR) || (state_q == LEN) || (state_q == DATA);
`ifdef DESER_LOAD_CHECKSUM_EN
        timed = timed || (state_q == CHK);
`endif
    end

    frame_timer #(
        .TIMEOUT_CYC (TIMEOUT_CYC)
    ) u_timer (
        .clk     (clk),
        .reset_n (reset_n),
        .load    (byte_valid || !timed),
        .enable  (timed),
        .timeout (timeout)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= IDLE;
            frame_err_q <= 1'b0;
            wr_sel_q    <= 1'b0;
            ptr_q       <= '0;
            left_q      <= '0;
            wr_en_q     <= 1'b0;
            wr_addr_q   <= '0;
            wr_data_q   <= '0;
`ifdef DESER_LOAD_CHECKSUM_EN
            csum_q      <= '0;
`endif
        end else begin
            // NOTE: non-blocking so every register samples the same pre-edge values.
            state_q     <= state_d;
            frame_err_q <= frame_err_d;
            wr_sel_q    <= wr_sel_d;
            ptr_q       <= ptr_d;
            left_q      <= left_d;
            wr_en_q     <= wr_en_d;
            wr_addr_q   <= wr_addr_d;
            wr_data_q   <= wr_data_d;
`ifdef DESER_LOAD_CHECKSUM_EN
            csum_q      <= csum_d;
`endif
        end
    end

    always_comb begin
        // NOTE: every target is defaulted first so no path can infer a latch.
        state_d     = state_q;
        frame_err_d = frame_err_q;
        wr_sel_d    = wr_sel_q;
        ptr_d       = ptr_q;
        left_d      = left_q;
        wr_en_d     = 1'b0;
        wr_addr_d   = wr_addr_q;
        wr_data_d   = wr_data_q;
`ifdef DESER_LOAD_CHECKSUM_EN
        csum_d      = csum_q;
`endif

        case (state_q)
            IDLE: begin
                if (byte_valid) begin
                    case (byte_in)
                        CMD_LOAD_W: begin
                            wr_sel_d    = 1'b0;
                            frame_err_d = 1'b0;
                            state_d     = ADDR;
                        end
                        CMD_LOAD_I: begin
                            wr_sel_d    = 1'b1;
                            frame_err_d = 1'b0;
                            state_d     = ADDR;
                        end
                        CMD_RUN: begin
                            frame_err_d = 1'b0;
                            state_d     = START;
                        end
                        default: frame_err_d = 1'b1;
                    endcase
                end
            end
            ADDR: begin
                if (byte_valid) begin
                    ptr_d   = ADDR_W'(byte_in);
                    state_d = LEN;
`ifdef DESER_LOAD_CHECKSUM_EN
                    csum_d  = byte_in;
`endif
                end
            end
            LEN: begin
                if (byte_valid) begin
                    left_d = byte_in;
`ifdef DESER_LOAD_CHECKSUM_EN
                    csum_d = csum_q ^ byte_in;
`endif
                    if (byte_in == 8'd0) begin
                        frame_err_d = 1'b1;
                        state_d     = IDLE;
                    end else begin
                        state_d = DATA;
                    end
                end
            end
            DATA: begin
                if (byte_valid) begin
                    wr_en_d   = 1'b1;
                    wr_addr_d = ptr_q;
                    wr_data_d = byte_in;
                    ptr_d     = ptr_q + ADDR_W'(1);
                    left_d    = left_q - 8'd1;
`ifdef DESER_LOAD_CHECKSUM_EN
                    csum_d    = csum_q ^ byte_in;
                    if (left_q == 8'd1) state_d = CHK;
`else
                    if (left_q == 8'd1) state_d = IDLE;
`endif
                end
            end
`ifdef DESER_LOAD_CHECKSUM_EN
            CHK: begin
                if (byte_valid) begin
                    if (byte_in != csum_q) frame_err_d = 1'b1;
                    state_d = IDLE;
                end
            end
`endif
            START: begin
                if (byte_valid) frame_err_d = 1'b1;
                state_d = WAIT_DONE;
            end
            WAIT_DONE: begin
                if (byte_valid) frame_err_d = 1'b1;
                if (nn_done)    state_d     = IDLE;
            end
            default: state_d = IDLE;
        endcase

        // Timeout only fires on byte-free cycles, so it never competes with a byte.
        if (timeout) begin
            frame_err_d = 1'b1;
            state_d     = IDLE;
        end
    end

    assign wr_en     = wr_en_q;
    assign wr_sel    = wr_sel_q;
    assign wr_addr   = wr_addr_q;
    assign wr_data   = wr_data_q;
    assign nn_start  = (state_q == START);
    assign ctrl_busy = (state_q != IDLE);
    assign frame_err = frame_err_q;

endmodule

// File: tb/tb_deser_load_ctrl.sv
// Self-checking bench for deser_load_ctrl: frame table plus hand-written
// run, timeout and reset sequences; writes are checked through a scoreboard.
module tb_deser_load_ctrl;

    localparam int ADDR_W = 8;
    localparam int TCYC   = 32;
`ifdef DESER_LOAD_CHECKSUM_EN
    localparam bit CSUM_EN = 1'b1;
`else
    localparam bit CSUM_EN = 1'b0;
`endif

    logic              clk = 1'b0;
    logic              reset_n = 1'b0;
    logic [7:0]        byte_in = '0;
    logic              byte_valid = 1'b0;
    logic              wr_en, wr_sel, nn_start, ctrl_busy, frame_err;
    logic [ADDR_W-1:0] wr_addr;
    logic [7:0]        wr_data;
    logic              nn_done = 1'b0;

    deser_load_ctrl #(.ADDR_W(ADDR_W), .TIMEOUT_CYC(TCYC)) dut (
        .clk        (clk),
        .reset_n    (reset_n),
        .byte_in    (byte_in),
        .byte_valid (byte_valid),
        .wr_en      (wr_en),
        .wr_sel     (wr_sel),
        .wr_addr    (wr_addr),
        .wr_data    (wr_data),
        .nn_start   (nn_start),
        .nn_done    (nn_done),
        .ctrl_busy  (ctrl_busy),
        .frame_err  (frame_err)
    );

    always #5 clk = ~clk;

    int total = 0;
    int bad   = 0;
    int start_cnt = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    typedef struct packed {
        logic       sel;
        logic [7:0] addr;
        logic [7:0] data;
    } wr_t;

    wr_t exp_q[$];

    // Monitor: pops the scoreboard on every write strobe.
    always @(negedge clk) begin
        wr_t e;
        if (wr_en || nn_start) check("wr_start_excl", {31'd0, wr_en & nn_start}, 32'd0);
        if (nn_start) start_cnt++;
        if (wr_en) begin
            if (exp_q.size() == 0) begin
                check("unexpected_wr", {16'd0, wr_addr, wr_data}, 32'hFFFF_FFFF);
            end else begin
                e = exp_q.pop_front();
                check("wr_sel",  {31'd0, wr_sel}, {31'd0, e.sel});
                check("wr_addr", {24'd0, wr_addr}, {24'd0, e.addr});
                check("wr_data", {24'd0, wr_data}, {24'd0, e.data});
            end
        end
    end

    task automatic send_byte(input logic [7:0] b);
        @(negedge clk);
        byte_in    = b;
        byte_valid = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0;
    endtask

    typedef struct {
        string       name;
        logic [7:0]  cmd;
        logic [7:0]  addr;
        logic [7:0]  len;
        logic [31:0] data;
        bit          bad_chk;
        bit          exp_err;
    } vec_t;

    function automatic vec_t mk(input string n, input logic [7:0] c, input logic [7:0] a,
                                input logic [7:0] l, input logic [31:0] d,
                                input bit bad_c, input bit err);
        vec_t v;
        v.name = n; v.cmd = c; v.addr = a; v.len = l; v.data = d;
        v.bad_chk = bad_c;
        v.exp_err = err | (bad_c & CSUM_EN);
        return v;
    endfunction

    vec_t vecs[7];

    initial begin
        logic [7:0] x;
        logic [7:0] d;
        int         s0;

        vecs[0] = mk("ld_w",      8'h01, 8'h10, 8'd3, 32'hAABBCC00, 1'b0, 1'b0);
        vecs[1] = mk("ld_i_wrap", 8'h02, 8'hFE, 8'd3, 32'h11223300, 1'b0, 1'b0);
        vecs[2] = mk("bad_cmd",   8'h7F, 8'h00, 8'd0, 32'h0,        1'b0, 1'b1);
        vecs[3] = mk("len_zero",  8'h01, 8'h40, 8'd0, 32'h0,        1'b0, 1'b1);
        vecs[4] = mk("err_clear", 8'h01, 8'h80, 8'd2, 32'h5AA50000, 1'b0, 1'b0);
        vecs[5] = mk("chk_bad",   8'h02, 8'h30, 8'd1, 32'hC3000000, 1'b1, 1'b0);
        vecs[6] = mk("ld_w4",     8'h01, 8'hFD, 8'd4, 32'hDEADBEEF, 1'b0, 1'b0);

        #1;
        check("rst_wr_en",  {31'd0, wr_en}, 32'd0);
        check("rst_wr_sel", {31'd0, wr_sel}, 32'd0);
        check("rst_addr",   {24'd0, wr_addr}, 32'd0);
        check("rst_data",   {24'd0, wr_data}, 32'd0);
        check("rst_start",  {31'd0, nn_start}, 32'd0);
        check("rst_busy",   {31'd0, ctrl_busy}, 32'd0);
        check("rst_err",    {31'd0, frame_err}, 32'd0);
        repeat (3) @(negedge clk);
        reset_n = 1'b1;

        for (int i = 0; i < 7; i++) begin
            send_byte(vecs[i].cmd);
            if (vecs[i].cmd == 8'h01 || vecs[i].cmd == 8'h02) begin
                send_byte(vecs[i].addr);
                send_byte(vecs[i].len);
                x = vecs[i].addr ^ vecs[i].len;
                for (int k = 0; k < int'(vecs[i].len); k++) begin
                    d = vecs[i].data[31-8*k -: 8];
                    exp_q.push_back('{sel: vecs[i].cmd[1], addr: vecs[i].addr + 8'(k), data: d});
                    send_byte(d);
                    check({vecs[i].name, "_lat"}, {31'd0, wr_en}, 32'd1);
                    x = x ^ d;
                end
                if (CSUM_EN && vecs[i].len != 8'd0)
                    send_byte(vecs[i].bad_chk ? ~x : x);
            end
            repeat (3) @(negedge clk);
            check({vecs[i].name, "_err"},  {31'd0, frame_err}, {31'd0, vecs[i].exp_err});
            check({vecs[i].name, "_busy"}, {31'd0, ctrl_busy}, 32'd0);
            check({vecs[i].name, "_sb"},   exp_q.size(), 32'd0);
        end

        // Run command with nn_done 20 cycles after the command byte.
        s0 = start_cnt;
        send_byte(8'h03);
        check("run_start", {31'd0, nn_start}, 32'd1);
        check("run_busy0", {31'd0, ctrl_busy}, 32'd1);
        @(negedge clk);
        check("run_start_1cyc", {31'd0, nn_start}, 32'd0);
        repeat (18) @(negedge clk);
        nn_done = 1'b1;
        check("run_busy_done", {31'd0, ctrl_busy}, 32'd1);
        @(negedge clk);
        nn_done = 1'b0;
        check("run_idle", {31'd0, ctrl_busy}, 32'd0);
        check("run_pulses", start_cnt - s0, 32'd1);

        // Byte while waiting for the core is dropped and flagged.
        send_byte(8'h03);
        send_byte(8'h55);
        check("wait_byte_err",  {31'd0, frame_err}, 32'd1);
        check("wait_byte_busy", {31'd0, ctrl_busy}, 32'd1);
        @(negedge clk); nn_done = 1'b1;
        @(negedge clk); nn_done = 1'b0;
        check("wait_byte_idle", {31'd0, ctrl_busy}, 32'd0);

        // Byte coinciding with nn_done.
        send_byte(8'h03);
        check("coin_clr", {31'd0, frame_err}, 32'd0);
        repeat (2) @(negedge clk);
        byte_in = 8'h66; byte_valid = 1'b1; nn_done = 1'b1;
        @(negedge clk);
        byte_valid = 1'b0; nn_done = 1'b0;
        check("coin_err",  {31'd0, frame_err}, 32'd1);
        check("coin_idle", {31'd0, ctrl_busy}, 32'd0);

        // Timeout inside DATA after one payload byte.
        send_byte(8'h01);
        send_byte(8'h00);
        send_byte(8'h05);
        exp_q.push_back('{sel: 1'b0, addr: 8'h00, data: 8'hAA});
        send_byte(8'hAA);
        repeat (TCYC - 1) @(negedge clk);
        check("to_busy_before", {31'd0, ctrl_busy}, 32'd1);
        check("to_err_before",  {31'd0, frame_err}, 32'd0);
        @(negedge clk);
        check("to_idle", {31'd0, ctrl_busy}, 32'd0);
        check("to_err",  {31'd0, frame_err}, 32'd1);
        check("to_sb",   exp_q.size(), 32'd0);

        // Reset mid-DATA, then a run command must be accepted as CMD.
        send_byte(8'h02);
        send_byte(8'h20);
        send_byte(8'h04);
        exp_q.push_back('{sel: 1'b1, addr: 8'h20, data: 8'hAA});
        exp_q.push_back('{sel: 1'b1, addr: 8'h21, data: 8'hBB});
        send_byte(8'hAA);
        send_byte(8'hBB);
        #2 reset_n = 1'b0;
        #1;
        check("mrst_wr_en",  {31'd0, wr_en}, 32'd0);
        check("mrst_wr_sel", {31'd0, wr_sel}, 32'd0);
        check("mrst_addr",   {24'd0, wr_addr}, 32'd0);
        check("mrst_data",   {24'd0, wr_data}, 32'd0);
        check("mrst_busy",   {31'd0, ctrl_busy}, 32'd0);
        check("mrst_err",    {31'd0, frame_err}, 32'd0);
        repeat (2) @(negedge clk);
        reset_n = 1'b1;
        s0 = start_cnt;
        send_byte(8'h03);
        check("mrst_start", {31'd0, nn_start}, 32'd1);
        repeat (3) @(negedge clk);
        nn_done = 1'b1;
        @(negedge clk);
        nn_done = 1'b0;
        check("mrst_idle",   {31'd0, ctrl_busy}, 32'd0);
        check("mrst_pulses", start_cnt - s0, 32'd1);
        check("final_sb",    exp_q.size(), 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
